// File: rtl/branch_predictor_table.sv
// Branch direction predictor: table of saturating counters indexed by PC
// (bimodal) or PC XOR global history (gshare), with saturating perf counters.
module branch_predictor_table #(
  parameter int PC_W   = 32,
  parameter int PC_LSB = 2,
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 6,
  parameter int MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [PC_W-1:0]   req_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};

  logic [CTR_W-1:0]  ctr_tbl [ENTRIES];
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [CTR_W-1:0]  ctr_upd;
  logic [CTR_W-1:0]  ctr_next;
  logic              unused_bits;

  // Only the index field of each PC is consumed; the rest is intentionally dropped.
  assign unused_bits = ^{req_pc, upd_pc, upd_hist};

  always_comb begin
    req_idx = req_pc[PC_LSB +: IDX_W];
    upd_idx = upd_pc[PC_LSB +: IDX_W];
    if (MODE == 1) begin
      req_idx = req_idx ^ IDX_W'(ghr);
      upd_idx = upd_idx ^ IDX_W'(upd_hist);
    end
  end

  always_comb begin
    ctr_upd  = ctr_tbl[upd_idx];
    ctr_next = ctr_upd;
    if (upd_taken) begin
      if (ctr_upd != '1) ctr_next = ctr_upd + CTR_W'(1);
    end else begin
      if (ctr_upd != '0) ctr_next = ctr_upd - CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_tbl[i] <= CTR_INIT;
    end else if (upd_valid) begin
      ctr_tbl[upd_idx] <= ctr_next;
    end
  end

  // Truncating cast of {ghr, taken} shifts the outcome into the LSB, also for HIST_W=1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (upd_valid && MODE == 1) begin
      ghr <= HIST_W'({ghr, upd_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_hist  <= '0;
    end else begin
      pred_valid <= req_valid;
      if (req_valid) begin
        pred_taken <= ctr_tbl[req_idx][CTR_W-1];
        pred_hist  <= ghr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (upd_valid) begin
      if (perf_branches != '1) perf_branches <= perf_branches + 32'd1;
      if (upd_taken != upd_pred && perf_mispred != '1) perf_mispred <= perf_mispred + 32'd1;
    end
  end

endmodule
